// File: rtl/alu_pkg.sv
// Shared opcode encodings, sequencer state encoding and command layout for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_INC = 4'b1001;
  localparam logic [3:0] OP_DEC = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  localparam int unsigned CMD_DATA_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0]            opcode;
    logic [CMD_DATA_W-1:0] operand_a;
    logic [CMD_DATA_W-1:0] operand_b;
    logic [1:0]            tag;
  } cmd_t;

  function automatic logic opcode_defined(input logic [3:0] op);
    return op <= OP_DEC;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU sequencer: DEPTH entries (power of two), WIDTH bits each, wrap-bit pointers.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  // Equal index with differing wrap bit means the writer lapped the reader.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands and issues them one at a time to a registered ALU, returning results in order.
// Optional ALU_SEQ_OPCODE_CHECK_EN: undefined opcodes are consumed, not queued, and flagged on cmd_error.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [DATA_W-1:0]   in_operand_a,
  input  logic [DATA_W-1:0]   in_operand_b,
  output logic [3:0]          alu_opcode,
  output logic [DATA_W-1:0]   alu_operand_a,
  output logic [DATA_W-1:0]   alu_operand_b,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_result,
  output logic [1:0]          out_tag,
  output logic                cmd_error
);

  // Same field order as alu_pkg::cmd_t, widened to this instance's DATA_W.
  typedef struct packed {
    logic [3:0]        opcode;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [1:0]        tag;
  } entry_t;

  state_t     state;
  logic [1:0] tag_cnt;
  logic [1:0] cur_tag;
  logic       accept;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  entry_t     push_entry;
  entry_t     head;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  assign push = accept && opcode_defined(in_opcode);

  always_ff @(posedge clk) begin
    if (reset) cmd_error <= 1'b0;
    else       cmd_error <= accept && !opcode_defined(in_opcode);
  end
`else
  assign push      = accept;
  assign cmd_error = 1'b0;
`endif

  assign push_entry = '{opcode: in_opcode, operand_a: in_operand_a,
                        operand_b: in_operand_b, tag: tag_cnt};

  // Head is taken whenever the engine is free: idle, or its result is being handed off.
  assign pop = !empty && ((state == ST_IDLE) || (state == ST_DONE && out_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tag_cnt       <= '0;
      cur_tag       <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_tag       <= '0;
      alu_opcode    <= OP_NOP;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
    end else begin
      if (push) tag_cnt <= tag_cnt + 2'd1;

      if (pop) begin
        alu_opcode    <= head.opcode;
        alu_operand_a <= head.operand_a;
        alu_operand_b <= head.operand_b;
        cur_tag       <= head.tag;
      end

      case (state)
        ST_IDLE: begin
          if (pop) state      <= ST_ISSUE;
          else     alu_opcode <= OP_NOP;
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          out_result <= alu_result;
          out_tag    <= cur_tag;
          out_valid  <= 1'b1;
          state      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              state <= ST_ISSUE;
            end else begin
              alu_opcode <= OP_NOP;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a one-cycle registered ALU model; honours ALU_SEQ_OPCODE_CHECK_EN.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [3:0]          in_opcode;
  logic [DATA_W-1:0]   in_operand_a;
  logic [DATA_W-1:0]   in_operand_b;
  logic [3:0]          alu_opcode;
  logic [DATA_W-1:0]   alu_operand_a;
  logic [DATA_W-1:0]   alu_operand_b;
  logic [2*DATA_W-1:0] alu_result = '0;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] out_result;
  logic [1:0]          out_tag;
  logic                cmd_error;

  int tests = 0;
  int fails = 0;

  alu_cmd_sequencer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_operand_a  (in_operand_a),
    .in_operand_b  (in_operand_b),
    .alu_opcode    (alu_opcode),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_tag       (out_tag),
    .cmd_error     (cmd_error)
  );

  always #5 clk = ~clk;

  function automatic logic [2*DATA_W-1:0] alu_f(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] xa;
    logic [2*DATA_W-1:0] xb;
    xa = {{DATA_W{1'b0}}, a};
    xb = {{DATA_W{1'b0}}, b};
    case (op)
      OP_ADD:  return xa + xb;
      OP_SUB:  return xa - xb;
      OP_MUL:  return xa * xb;
      OP_AND:  return xa & xb;
      OP_OR:   return xa | xb;
      OP_XOR:  return xa ^ xb;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_operand_a, alu_operand_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    in_valid     = 1'b1;
    in_opcode    = op;
    in_operand_a = a;
    in_operand_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [3:0]          v_op  [5];
  logic [DATA_W-1:0]   v_a   [5];
  logic [DATA_W-1:0]   v_b   [5];
  logic [2*DATA_W-1:0] v_res [5];
  logic [1:0]          v_tag [5];

  initial begin
    int cyc;
    logic seen;

    v_op[0] = OP_ADD; v_a[0] = 16'hFFFF; v_b[0] = 16'h0001; v_res[0] = 32'h0001_0000; v_tag[0] = 2'd0;
    v_op[1] = OP_SUB; v_a[1] = 16'd100;  v_b[1] = 16'd1;    v_res[1] = 32'd99;        v_tag[1] = 2'd1;
    v_op[2] = OP_MUL; v_a[2] = 16'hFFFF; v_b[2] = 16'hFFFF; v_res[2] = 32'hFFFE_0001; v_tag[2] = 2'd2;
    v_op[3] = OP_AND; v_a[3] = 16'hF0F0; v_b[3] = 16'hFF00; v_res[3] = 32'h0000_F000; v_tag[3] = 2'd3;
    v_op[4] = OP_XOR; v_a[4] = 16'hFFFF; v_b[4] = 16'h00FF; v_res[4] = 32'h0000_FF00; v_tag[4] = 2'd0;

    in_valid = 1'b0; in_opcode = '0; in_operand_a = '0; in_operand_b = '0;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    check("rst_in_ready",   64'(in_ready),      64'd1);
    check("rst_out_valid",  64'(out_valid),     64'd0);
    check("rst_out_result", 64'(out_result),    64'd0);
    check("rst_out_tag",    64'(out_tag),       64'd0);
    check("rst_alu_opcode", 64'(alu_opcode),    64'hF);
    check("rst_alu_a",      64'(alu_operand_a), 64'd0);
    check("rst_alu_b",      64'(alu_operand_b), 64'd0);
    check("rst_cmd_error",  64'(cmd_error),     64'd0);

    // Single ADD: latency and hold under backpressure
    push_one(OP_ADD, 16'd10, 16'd5);
    wait_valid("add_valid", cyc);
    check("add_latency", 64'(cyc),        64'd3);
    check("add_result",  64'(out_result), 64'd15);
    check("add_tag",     64'(out_tag),    64'd0);
    tick();
    tick();
    check("add_hold_valid",  64'(out_valid),  64'd1);
    check("add_hold_result", 64'(out_result), 64'd15);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("add_handoff_valid", 64'(out_valid),  64'd0);
    check("idle_nop",          64'(alu_opcode), 64'hF);

    // Fill: first command goes in flight, the next four fill the FIFO
    pulse_reset();
    for (int unsigned i = 0; i < 5; i++) push_one(v_op[i], v_a[i], v_b[i]);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_opcode = OP_ADD; in_operand_a = 16'd1; in_operand_b = 16'd1;
    tick();
    tick();
    check("full_in_ready_held", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    out_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      wait_valid($sformatf("seq%0d_valid", i), cyc);
      if (i > 0) check($sformatf("seq%0d_spacing", i), 64'(cyc + 1), 64'd3);
      check($sformatf("seq%0d_result", i), 64'(out_result), 64'(v_res[i]));
      check($sformatf("seq%0d_tag", i),    64'(out_tag),    64'(v_tag[i]));
      tick();
    end
    seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("dropped_push_no_result", 64'(seen),       64'd0);
    check("drained_nop",            64'(alu_opcode), 64'hF);

    // Reset while WAIT with two commands queued
    push_one(OP_ADD, 16'd3, 16'd4);
    push_one(OP_SUB, 16'd9, 16'd2);
    push_one(OP_OR,  16'd1, 16'd2);
    check("wait_alu_a_loaded", 64'(alu_operand_a), 64'd3);
    pulse_reset();
    check("mid_rst_out_valid",  64'(out_valid),     64'd0);
    check("mid_rst_out_result", 64'(out_result),    64'd0);
    check("mid_rst_out_tag",    64'(out_tag),       64'd0);
    check("mid_rst_alu_opcode", 64'(alu_opcode),    64'hF);
    check("mid_rst_alu_a",      64'(alu_operand_a), 64'd0);
    check("mid_rst_alu_b",      64'(alu_operand_b), 64'd0);
    check("mid_rst_in_ready",   64'(in_ready),      64'd1);
    seen = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);

    // Undefined opcode 4'b1100, then a defined command to observe the tag counter
    push_one(4'b1100, 16'd7, 16'd9);
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    check("bad_op_cmd_error", 64'(cmd_error), 64'd1);
    tick();
    check("bad_op_error_pulse", 64'(cmd_error), 64'd0);
    seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("bad_op_no_valid", 64'(seen), 64'd0);
    push_one(OP_ADD, 16'd2, 16'd3);
    wait_valid("after_bad_valid", cyc);
    check("after_bad_result", 64'(out_result), 64'd5);
    check("after_bad_tag",    64'(out_tag),    64'd0);
`else
    check("bad_op_cmd_error", 64'(cmd_error), 64'd0);
    wait_valid("bad_op_valid", cyc);
    check("bad_op_result", 64'(out_result), 64'd0);
    check("bad_op_tag",    64'(out_tag),    64'd0);
    push_one(OP_ADD, 16'd2, 16'd3);
    wait_valid("after_bad_valid", cyc);
    check("after_bad_result", 64'(out_result), 64'd5);
    check("after_bad_tag",    64'(out_tag),    64'd1);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
